// File: rtl/turn_pkg.sv
// Shared types and constants for the turn manoeuvre sequencer.
package turn_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND       = 3'd1,
    TURN       = 3'd2,
    TURN_GAP   = 3'd3,
    FOLLOW     = 3'd4,
    FOLLOW_GAP = 3'd5,
    DONE       = 3'd6,
    FAIL       = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    DIR_LEFT     = 2'b00,
    DIR_RIGHT    = 2'b01,
    DIR_UTURN    = 2'b10,
    DIR_STRAIGHT = 2'b11
  } dir_t;

  typedef struct packed {
    logic l_reset;
    logic l_dir;
    logic r_reset;
    logic r_dir;
  } motor_cmd_t;

  // Forward is left dir 1, right dir 0 (motors are mounted mirrored).
  localparam motor_cmd_t MOTOR_OFF   = '{l_reset: 1'b1, l_dir: 1'b0, r_reset: 1'b1, r_dir: 1'b0};
  localparam motor_cmd_t FWD         = '{l_reset: 1'b0, l_dir: 1'b1, r_reset: 1'b0, r_dir: 1'b0};
  localparam motor_cmd_t SPIN_L      = '{l_reset: 1'b0, l_dir: 1'b0, r_reset: 1'b0, r_dir: 1'b0};
  localparam motor_cmd_t SPIN_R      = '{l_reset: 1'b0, l_dir: 1'b1, r_reset: 1'b0, r_dir: 1'b1};
  localparam motor_cmd_t L_OFF_R_FWD = '{l_reset: 1'b1, l_dir: 1'b0, r_reset: 1'b0, r_dir: 1'b0};
  localparam motor_cmd_t R_OFF_L_FWD = '{l_reset: 1'b0, l_dir: 1'b1, r_reset: 1'b1, r_dir: 1'b0};

  function automatic logic [7:0] tx_code(input logic [7:0] base, input dir_t d);
    return base + {6'b0, d};
  endfunction

endpackage

// File: rtl/follow_lut.sv
// Combinational line-follow table: sensor pattern (l,m,r) to motor command.
module follow_lut
  import turn_pkg::*;
(
  input  logic       sensor_l,
  input  logic       sensor_m,
  input  logic       sensor_r,
  output motor_cmd_t cmd
);

  always_comb begin
    cmd = MOTOR_OFF;
    case ({sensor_l, sensor_m, sensor_r})
      3'b000:  cmd = FWD;
      3'b001:  cmd = L_OFF_R_FWD;
      3'b010:  cmd = FWD;
      3'b011:  cmd = SPIN_L;
      3'b100:  cmd = R_OFF_L_FWD;
      3'b101:  cmd = FWD;
      3'b110:  cmd = SPIN_R;
      default: cmd = MOTOR_OFF;
    endcase
  end

endmodule

// File: rtl/turn_sequencer.sv
// Turn manoeuvre sequencer: UART report, blind-then-sensed spin, timed
// line-follow, then done/timeout handshake with the mission controller.
module turn_sequencer
  import turn_pkg::*;
#(
  parameter int unsigned CNT_W       = 30,
  parameter int unsigned PULSE_CYC   = 2_000_000,
  parameter int unsigned BLIND_CYC   = 55_000_000,
  parameter int unsigned FOLLOW_CYC  = 34_000_000,
  parameter int unsigned TIMEOUT_CYC = 300_000_000,
  parameter logic [7:0]  TX_BASE     = 8'd68
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dir,
  input  logic       sensor_l,
  input  logic       sensor_m,
  input  logic       sensor_r,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       motor_l_reset,
  output logic       motor_r_reset,
  output logic       motor_l_direction,
  output logic       motor_r_direction,
  output logic       motor_brake,
  output logic       done,
  output logic       timeout
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
    $fatal(1, "turn_sequencer: CNT_W must be in 2..32");
  end
  if (PULSE_CYC < 1 || BLIND_CYC < 1 || FOLLOW_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_zero
    $fatal(1, "turn_sequencer: timing parameters must be non-zero");
  end
  if (64'(PULSE_CYC) > CNT_MAX || 64'(BLIND_CYC) * 64'd2 > CNT_MAX ||
      64'(FOLLOW_CYC) > CNT_MAX || 64'(TIMEOUT_CYC) > CNT_MAX) begin : g_bad_fit
    $fatal(1, "turn_sequencer: timing parameters do not fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] BLIND_LIM   = CNT_W'(BLIND_CYC);
  localparam logic [CNT_W-1:0] UTURN_LIM   = CNT_W'(64'(BLIND_CYC) * 64'd2);
  localparam logic [CNT_W-1:0] FOLLOW_LAST = CNT_W'(FOLLOW_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  state_t           state, state_n;
  dir_t             dir_q;
  logic [CNT_W-1:0] pulse_cnt, blind_cnt, tmo_cnt, follow_cnt;
  motor_cmd_t       lut_cmd, cmd;

  logic             in_turn, in_follow, next_in_turn, next_in_follow;
  logic             reacq, tmo_hit;
  logic [CNT_W-1:0] blind_lim;

  follow_lut u_follow_lut (
    .sensor_l (sensor_l),
    .sensor_m (sensor_m),
    .sensor_r (sensor_r),
    .cmd      (lut_cmd)
  );

  assign in_turn        = (state == TURN) || (state == TURN_GAP);
  assign in_follow      = (state == FOLLOW) || (state == FOLLOW_GAP);
  assign next_in_turn   = (state_n == TURN) || (state_n == TURN_GAP);
  assign next_in_follow = (state_n == FOLLOW) || (state_n == FOLLOW_GAP);

  assign blind_lim = (dir_q == DIR_UTURN) ? UTURN_LIM : BLIND_LIM;
  assign reacq     = (blind_cnt >= blind_lim) &&
                     ((dir_q == DIR_RIGHT) ? !sensor_r : !sensor_l);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);

  // Priority inside the turn: timeout, then re-acquisition, then pulse gap.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = SEND;
      SEND: if (tx_ready) state_n = (dir_q == DIR_STRAIGHT) ? FOLLOW : TURN;
      TURN, TURN_GAP: begin
        if (tmo_hit)                                    state_n = FAIL;
        else if (reacq)                                 state_n = FOLLOW;
        else if (state == TURN_GAP)                     state_n = TURN;
        else if (pulse_cnt == PULSE_LAST)               state_n = TURN_GAP;
      end
      FOLLOW, FOLLOW_GAP: begin
        if (follow_cnt == FOLLOW_LAST)                  state_n = DONE;
        else if (state == FOLLOW_GAP)                   state_n = FOLLOW;
        else if (pulse_cnt == PULSE_LAST)               state_n = FOLLOW_GAP;
      end
      DONE, FAIL: if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dir_q      <= DIR_LEFT;
      pulse_cnt  <= '0;
      blind_cnt  <= '0;
      tmo_cnt    <= '0;
      follow_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) dir_q <= dir_t'(dir);
      // Each counter restarts whenever its span is entered afresh.
      pulse_cnt  <= (((state == TURN) && (state_n == TURN)) ||
                     ((state == FOLLOW) && (state_n == FOLLOW))) ? sat_inc(pulse_cnt) : '0;
      blind_cnt  <= (in_turn && next_in_turn) ? sat_inc(blind_cnt) : '0;
      tmo_cnt    <= (in_turn && next_in_turn) ? sat_inc(tmo_cnt) : '0;
      follow_cnt <= (in_follow && next_in_follow) ? sat_inc(follow_cnt) : '0;
    end
  end

  always_comb begin
    cmd         = MOTOR_OFF;
    motor_brake = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    case (state)
      SEND: begin
        tx_valid    = 1'b1;
        tx_data     = tx_code(TX_BASE, dir_q);
        motor_brake = 1'b1;
      end
      TURN:   cmd = (dir_q == DIR_RIGHT) ? SPIN_R : SPIN_L;
      FOLLOW: cmd = lut_cmd;
      DONE: begin
        motor_brake = 1'b1;
        done        = 1'b1;
      end
      FAIL: begin
        motor_brake = 1'b1;
        timeout     = 1'b1;
      end
      default: ;
    endcase
  end

  assign motor_l_reset     = cmd.l_reset;
  assign motor_l_direction = cmd.l_dir;
  assign motor_r_reset     = cmd.r_reset;
  assign motor_r_direction = cmd.r_dir;

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Parametrised successor to the fixed left U-turn manoeuvre block in the line-follower controller.
- On `start`, it does the following in order:
  - reports the manoeuvre code over the UART transmitter;
  - spins left, spins right, or goes straight, per `dir`, until the line is re-acquired;
  - line-follows for a fixed window;
  - signals `done`.
- Adds configurable timings, direction select, a timeout/fail path and a start/done handshake.
- Sits between the top-level mission controller and the motor PWM/UART blocks.

Parameters:
- CNT_W, 30, width of all internal counters.
- PULSE_CYC, 2_000_000, motor-on cycles per drive pulse; each pulse is followed by one motor-off gap cycle.
- BLIND_CYC, 55_000_000, cycles after turn start during which sensors are ignored.
- FOLLOW_CYC, 34_000_000, line-follow duration after re-acquisition.
- TIMEOUT_CYC, 300_000_000, maximum cycles spent in TURN/TURN_GAP before FAIL.
- TX_BASE, 8'd68, UART code base; the byte sent is TX_BASE + dir.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  level request from mission controller; sampled in IDLE
- dir  in  2  00 spin-left, 01 spin-right, 10 U-turn (spin-left, longer blind), 11 straight (no turn)
- sensor_l, sensor_m, sensor_r  in  1 each  line sensors, 0 = black line seen
- tx_ready  in  1  UART accepts a byte
- tx_data  out  8  UART byte
- tx_valid  out  1  UART byte valid
- motor_l_reset, motor_r_reset  out  1 each  1 = motor off
- motor_l_direction, motor_r_direction  out  1 each  forward = l:1, r:0
- motor_brake  out  1  brake request
- done  out  1  manoeuvre complete
- timeout  out  1  manoeuvre failed

Behaviour:
- **Outputs**
  - Decoded combinationally from the registered state and counters.
- **Reset**
  - Synchronous; goes to IDLE and clears all counters.
  - Output values in IDLE/reset: motor resets 1, both directions 0, brake 0, done 0, timeout 0, tx_valid 0, tx_data 0.
  - Asserting reset mid-manoeuvre aborts on the next edge, with no UART byte and no done.
- **IDLE**
  - When `start` is 1, latch `dir` into dir_q and go to SEND. `dir` changes after this are ignored.
- **SEND**
  - tx_data = TX_BASE + dir_q; tx_valid = 1; motors off; brake = 1.
  - On the cycle tx_ready & tx_valid are both 1, the byte transfers.
  - Next state: TURN if dir_q != 11, else FOLLOW.
  - tx_valid is held until that transfer happens.
- **TURN**
  - Spin-left (00, 10): l_dir 0, r_dir 0.
  - Spin-right (01): l_dir 1, r_dir 1.
  - Motor resets 0.
  - The pulse counter runs. When it reaches PULSE_CYC-1, go to TURN_GAP for 1 cycle (motors off), then back to TURN.
  - The blind counter runs continuously through TURN and TURN_GAP. The blind limit is BLIND_CYC, or 2*BLIND_CYC for U-turn.
  - Re-acquisition, checked only after the blind limit: sensor_l==0 for spin-left, sensor_r==0 for spin-right. Go to FOLLOW; the pulse counter and follow counter clear.
  - If re-acquisition and the gap boundary fall on the same cycle, re-acquisition wins.
- **TIMEOUT**
  - The timeout counter counts cycles in TURN/TURN_GAP.
  - At TIMEOUT_CYC it forces FAIL, with priority over re-acquisition.
- **FOLLOW**
  - Pulsed drive with FOLLOW_GAP, identical to TURN pulse timing.
  - Motor command by (l,m,r):
    - 000 forward
    - 001 left motor off, right forward
    - 010 forward
    - 011 spin-left
    - 100 right motor off, left forward
    - 101 forward
    - 110 spin-right
    - 111 both off
  - The follow counter spans FOLLOW and FOLLOW_GAP. At FOLLOW_CYC, go to DONE.
- **DONE**
  - Motors off, brake 1, done 1.
  - Held until start==0, then IDLE.
  - If start stays high, there is no retrigger.
- **FAIL**
  - Motors off, brake 1, timeout 1.
  - Held until start==0, then IDLE.
- **Counter widths**
  - All counters are CNT_W bits and saturate, never wrap.
  - Parameters are checked at elaboration to fit in CNT_W.

Decomposition:
- Shared package `turn_pkg` contains:
  - the state enum: IDLE, SEND, TURN, TURN_GAP, FOLLOW, FOLLOW_GAP, DONE, FAIL;
  - the dir enum;
  - packed struct motor_cmd_t {l_reset, l_dir, r_reset, r_dir};
  - constants MOTOR_OFF, FWD, SPIN_L, SPIN_R.
- One sub-module, `follow_lut`: combinational sensors → motor_cmd_t table.
- Counters are built inline, replacing external timebase instances.

Test Plan (sim params: PULSE_CYC=10, BLIND_CYC=50, FOLLOW_CYC=200, TIMEOUT_CYC=500):
- **SEND hold:** start=1, dir=00, tx_ready=0 for 20 cycles then 1 → tx_valid held at 1 with tx_data=68 for 20 cycles; one transfer; TURN on the next cycle.
- **Left turn:** dir=00, sensor_l=0 from cycle 0 → still turning until blind (50) elapses; FOLLOW entered at blind+1; gap cycle with motors off every 11 cycles; done=1 after 200 follow cycles.
- **Right turn / U-turn:** dir=01 with sensor_l=0, sensor_r=1 → no exit, timeout=1 at cycle 500 with brake=1. dir=10 → no re-acquisition before cycle 100.
- **Straight:** dir=11 → tx_data=71, SEND goes straight to FOLLOW.
- **Follow table:** sweep all 8 sensor codes in FOLLOW → motor outputs match the table each cycle.
- **Reset / retrigger:** reset asserted mid-TURN → all outputs at reset values on the next cycle. In DONE, start held high keeps done=1; start=0 returns to IDLE.
